// File: rtl/axi_i2s2_regs_slave.sv
// AXI4-Lite register block for the AXI_I2S2 IP: four 32-bit control/status registers
// with byte-strobed writes, independent AW/W acceptance and held B/R responses.
module axi_i2s2_regs_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
  output logic [3:0]                        wr_pulse_o
);

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid && ready are both high; valid, once raised, holds with stable payload until then.

  logic [31:0] regs [4];
  logic        ready_en;
  logic        aw_held;
  logic [1:0]  aw_addr_q;
  logic        w_held;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [3:0]  wr_pulse_q;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic [1:0]  wsel;
  logic [31:0] wdata_sel;
  logic [3:0]  wstrb_sel;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = !aw_held && !bvalid_q && ready_en;
  assign S_AXI_WREADY  = !w_held && !bvalid_q && ready_en;
  assign S_AXI_ARREADY = !rvalid_q && ready_en;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A write commits as soon as both halves are present, whether latched earlier or arriving now.
  assign commit    = (aw_held || aw_hs) && (w_held || w_hs);
  assign wsel      = aw_held ? aw_addr_q : S_AXI_AWADDR[3:2];
  assign wdata_sel = w_held ? w_data_q : S_AXI_WDATA;
  assign wstrb_sel = w_held ? w_strb_q : S_AXI_WSTRB;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      ready_en   <= 1'b0;
      aw_held    <= 1'b0;
      aw_addr_q  <= '0;
      w_held     <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      ready_en   <= 1'b1;
      wr_pulse_q <= '0;
      if (commit) begin
        for (int b = 0; b < 4; b++)
          if (wstrb_sel[b]) regs[wsel][8*b +: 8] <= wdata_sel[8*b +: 8];
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
        bvalid_q       <= 1'b1;
        wr_pulse_q     <= 4'b0001 << wsel;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      end
    end
  end

  // Non-blocking read of regs yields the pre-write value when a commit hits the same edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = 2'b00;
  assign wr_pulse_o   = wr_pulse_q;
  assign reg0_o       = regs[0];
  assign reg1_o       = regs[1];
  assign reg2_o       = regs[2];
  assign reg3_o       = regs[3];

endmodule

// File: tb/tb_axi_i2s2_regs_slave.sv
// Directed bench for axi_i2s2_regs_slave: table of write/read vectors plus
// hand-written sequences for ordering, back-pressure, same-edge and reset corners.
module tb_axi_i2s2_regs_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_pulse;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  axi_i2s2_regs_slave dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .wr_pulse_o(wr_pulse)
  );

  typedef struct {
    bit          is_rd;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [31:0] get_reg(input logic [1:0] idx);
    case (idx)
      2'd0: return reg0;
      2'd1: return reg1;
      2'd2: return reg2;
      default: return reg3;
    endcase
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_reg);
    int  n;
    bit  aw_done, w_done, hs_aw, hs_w;
    logic [3:0] exp_pulse;
    exp_pulse = 4'b0001 << a[3:2];
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      n++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid = 1'b0;  w_done = 1;  end
    end
    if (!(aw_done && w_done)) begin
      check("write_timeout", 32'(n), 32'd0);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    check("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
    check("reg_after_write", get_reg(a[3:2]), exp_reg);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_clear", 32'(bvalid), 32'd0);
    check("wr_pulse_clear", 32'(wr_pulse), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      check("read_timeout", 32'(n), 32'd0);
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid", 32'(rvalid), 32'd1);
    check("rdata", rdata, exp);
    check("rresp", 32'(rresp), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 4'h0, 32'h1,        4'hF, 32'h1};
    vecs[1]  = '{0, 4'h4, 32'h2,        4'hF, 32'h2};
    vecs[2]  = '{0, 4'h8, 32'h3,        4'hF, 32'h3};
    vecs[3]  = '{0, 4'hC, 32'h4,        4'hF, 32'h4};
    vecs[4]  = '{1, 4'h0, 32'h0,        4'h0, 32'h1};
    vecs[5]  = '{1, 4'h4, 32'h0,        4'h0, 32'h2};
    vecs[6]  = '{1, 4'h8, 32'h0,        4'h0, 32'h3};
    vecs[7]  = '{1, 4'hC, 32'h0,        4'h0, 32'h4};
    vecs[8]  = '{0, 4'h4, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[9]  = '{0, 4'h4, 32'h12345678, 4'h5, 32'hFF34FF78};
    vecs[10] = '{1, 4'h4, 32'h0,        4'h0, 32'hFF34FF78};
    vecs[11] = '{0, 4'h4, 32'hDEADBEEF, 4'h0, 32'hFF34FF78};
    vecs[12] = '{0, 4'h1, 32'h000000AA, 4'hF, 32'h000000AA};
    vecs[13] = '{1, 4'h3, 32'h0,        4'h0, 32'h000000AA};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_pulse", 32'(wr_pulse), 32'd0);
    check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {29'd0, awready, wready, arready}, 32'd7);

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].exp);
      else do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp);
    end

    // W three cycles ahead of AW
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    check("wfirst_wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    check("wfirst_wready_drop", 32'(wready), 32'd0);
    repeat (2) @(negedge clk);
    check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
    check("wfirst_wready_held", 32'(wready), 32'd0);
    awvalid = 1'b1;
    check("wfirst_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    check("wfirst_reg3", reg3, 32'h11111111);
    check("wfirst_pulse", 32'(wr_pulse), 32'h8);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("wfirst_bclear", 32'(bvalid), 32'd0);

    // AW two cycles ahead of W
    @(negedge clk);
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0;
    check("awfirst_awready_drop", 32'(awready), 32'd0);
    @(negedge clk);
    check("awfirst_no_bvalid", 32'(bvalid), 32'd0);
    wvalid = 1'b1;
    check("awfirst_wready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    check("awfirst_bvalid", 32'(bvalid), 32'd1);
    check("awfirst_reg3", reg3, 32'h22222222);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;

    // B back-pressure blocks a second write
    do_write(4'h0, 32'h55, 4'hF, 32'h55);
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_first_bvalid", 32'(bvalid), 32'd1);
    check("bp_first_reg0", reg0, 32'h77);
    awdata_stall: begin
      awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h66;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("bp_bvalid_hold", 32'(bvalid), 32'd1);
        check("bp_ready_low", {30'd0, awready, wready}, 32'd0);
        check("bp_reg0_hold", reg0, 32'h77);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bp_bvalid_clear", 32'(bvalid), 32'd0);
      check("bp_ready_back", {30'd0, awready, wready}, 32'd3);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("bp_second_bvalid", 32'(bvalid), 32'd1);
      check("bp_second_reg0", reg0, 32'h66);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end

    // R back-pressure: RDATA stable even when the register changes underneath
    @(negedge clk);
    araddr = 4'h4; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rp_rvalid_hold", 32'(rvalid), 32'd1);
      check("rp_rdata_hold", rdata, 32'hFF34FF78);
      check("rp_arready_low", 32'(arready), 32'd0);
    end
    do_write(4'h4, 32'h0BADF00D, 4'hF, 32'h0BADF00D);
    check("rp_rdata_after_write", rdata, 32'hFF34FF78);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rp_rvalid_clear", 32'(rvalid), 32'd0);
    check("rp_rdata_keep", rdata, 32'hFF34FF78);

    // AR and commit to the same register on one edge
    do_write(4'h8, 32'hA, 4'hF, 32'hA);
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'hB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_rdata", rdata, 32'hA);
    check("same_edge_reg2", reg2, 32'hB);
    check("same_edge_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    do_read(4'h8, 32'hB);

    // reset while AW is held and W is still pending
    @(negedge clk);
    awaddr = 4'h0; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("mid_aw_held", 32'(awready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_bvalid", 32'(bvalid), 32'd0);
    end
    do_write(4'h4, 32'h5A5A5A5A, 4'hF, 32'h5A5A5A5A);
    check("post_rst_reg0", reg0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_i2s2_regs_slave.md
Name: axi_i2s2_regs_slave

Overview:
AXI4-Lite responder providing the four 32-bit control/status registers of the AXI_I2S2 IP. The VIP master and the PS drive this block. It decodes offsets 0x0, 0x4, 0x8 and 0xC. It exposes the register contents and per-register write strobes to the I2S2 datapath. It accepts AW and W independently, in either order, and holds B/R responses until the master accepts them.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte-address width; bits [3:2] select the register and bits [1:0] are ignored.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00 (OKAY)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg0_o..reg3_o  out  32 each  current register contents
wr_pulse_o  out  4  one-cycle pulse, bit n set on the edge register n is written

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All registers = 0.
  - BVALID, RVALID, wr_pulse_o = 0; RDATA = 0.
  - AW/W holding flags cleared.
  - AWREADY, WREADY, ARREADY = 0 while reset is asserted; they go to 1 on the first clock edge after release.
- A transaction in flight when reset asserts is dropped; no response is issued after reset.
- Write channel state: aw_held flag plus latched address; w_held flag plus latched data/strobe.
  - AWREADY = !aw_held && !BVALID && !in_reset.
  - WREADY = !w_held && !BVALID && !in_reset.
  - AW handshake without W available: latch the address and set aw_held. W alone is handled symmetrically.
  - Commit: on the edge where the address is available (aw_held or an AW handshake this cycle) and the data is available (w_held or a W handshake this cycle).
  - At commit: register[addr[3:2]] byte lanes with WSTRB=1 take WDATA; lanes with WSTRB=0 keep their value. WSTRB=0000 writes nothing but still responds OKAY.
  - At commit: BVALID is set, both held flags clear, and wr_pulse_o[n] is high for exactly the following cycle.
  - Latency: AW and W in the same cycle → BVALID high the next cycle, and regN_o shows the new value that same cycle.
  - BVALID holds until BREADY is sampled high; it clears on that edge. No new AW/W is accepted while BVALID=1, so at most one write is outstanding. Sustained throughput is one write per 2 cycles when BREADY is held high.
- Read channel:
  - ARREADY = !RVALID && !in_reset.
  - On AR handshake: RDATA <= register[ARADDR[3:2]] and RVALID <= 1 at the same edge, giving 1-cycle latency.
  - RVALID and RDATA hold stable until RREADY is sampled high. RVALID clears on that edge; RDATA holds its last value.
- Simultaneous events:
  - Read and write are fully independent.
  - If an AR handshake and a write commit hit the same register on the same edge, RDATA returns the pre-write value. The next read returns the new value.
- Out-of-range addresses cannot occur with 4-bit addressing; all four offsets are read/write.
- regN_o are driven directly from the register flops with no added latency.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then 4 reads → RDATA 0x1..0x4, all BRESP/RRESP = OKAY, wr_pulse_o = 0001, 0010, 0100, 1000 in order.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB=0101 → read of 0x4 returns 0xFF34FF78.
- W presented 3 cycles before AW, then AW presented 2 cycles before W → WREADY/AWREADY drop after the first handshake, one BVALID per write, data correct both times.
- BREADY held low 5 cycles after a write → BVALID stays high, AWREADY=WREADY=0 throughout, and a second write waits until B completes. Same check with RREADY low: RDATA stable, ARREADY=0.
- reg2 = 0xA; AR to 0x8 and commit of 0xB to 0x8 on the same edge → RDATA = 0xA, next read = 0xB.
- ARESETN pulsed low mid-write (AW accepted, W pending) → BVALID never rises, all regN_o = 0, and a fresh write afterward completes normally.
